jk_ff_exerciser: RTL and testbench

- Synthesizable driver/checker for the far end of a JK flip-flop interface.
- Drives j/k to a JK_ff instance from a programmed step pattern and samples q/q_bar after each DUT clock edge.
- Compares the samples against an internal JK reference model and reports pass/fail, error count and the first failing step.
- Used for on-chip self-test of JK storage cells and as a reusable bench component.

---
 rtl/jk_ff_exerciser_if.sv | 31 +++
 rtl/jk_ff_exerciser.sv | 174 +++++++++++++++++
 tb/tb_jk_ff_exerciser.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/jk_ff_exerciser_if.sv
// Handshake/bus bundle between the JK exerciser and its host.
// master = exerciser side, slave = host/DUT side.
interface jk_ff_exerciser_if #(
  parameter int STEPS = 8,
  parameter int IDX_W = 4,
  parameter int CNT_W = 4
);
  logic               start;
  logic [2*STEPS-1:0] pattern;
  logic               j;
  logic               k;
  logic               q_in;
  logic               q_bar_in;
  logic               busy;
  logic               done;
  logic               pass;
  logic [CNT_W-1:0]   err_cnt;
  logic [IDX_W-1:0]   err_step;

  modport master (
    input  start, pattern, q_in, q_bar_in,
    output j, k, busy, done, pass,
    output err_cnt, err_step
  );

  modport slave (
    output start, pattern, q_in, q_bar_in,
    input  j, k, busy, done, pass,
    input  err_cnt, err_step
  );
endinterface

// File: rtl/jk_ff_exerciser.sv
// JK flip-flop driver/checker with internal reference model.
// Optional q_bar consistency check: define JK_CHK_QBAR_EN.
module jk_ff_exerciser #(
  parameter int STEPS = 8,
  parameter int IDX_W = 4,
  parameter int CNT_W = 4
) (
  input logic clk,
  input logic rst_n,
  jk_ff_exerciser_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, INIT_APPLY, INIT_CHECK,
    APPLY, CHECK, DONE
  } state_e;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(STEPS-1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  state_e             state_q, state_d;
  logic [2*STEPS-1:0] pat_q, pat_d;
  logic [IDX_W-1:0]   idx_q, idx_d, idx_inc;
  logic [IDX_W-1:0]   est_q, est_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_sat;
  logic [CNT_W:0]     cnt_sum;
  logic               j_q, j_d, k_q, k_d;
  logic               model_q, model_d;
  logic               first_q, first_d;
  logic               pass_q, pass_d;
  logic               q_mis, qb_mis;
  logic [1:0]         n_mis;
  logic [1:0]         step_cur, step_nxt;

  assign idx_inc = idx_q + IDX_W'(1);

  always_comb begin
    step_cur = '0;
    step_nxt = '0;
    for (int i = 0; i < STEPS; i++) begin
      if (idx_q == IDX_W'(i)) step_cur = pat_q[2*i +: 2];
      if (idx_inc == IDX_W'(i)) step_nxt = pat_q[2*i +: 2];
    end
  end

  // Equality-in-if so an unknown q_in lands on the mismatch side
  always_comb begin
    q_mis = 1'b1;
    if (bus.q_in == model_q) q_mis = 1'b0;
`ifdef JK_CHK_QBAR_EN
    qb_mis = 1'b1;
    if (bus.q_bar_in == ~bus.q_in) qb_mis = 1'b0;
`else
    qb_mis = 1'b0;
`endif
  end

`ifndef JK_CHK_QBAR_EN
  logic unused_qbar;
  assign unused_qbar = bus.q_bar_in;
`endif

  assign n_mis   = {1'b0, q_mis} + {1'b0, qb_mis};
  assign cnt_sum = {1'b0, cnt_q}
                 + {{(CNT_W-1){1'b0}}, n_mis};
  assign cnt_sat = cnt_sum[CNT_W] ? CMAX
                 : cnt_sum[CNT_W-1:0];

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    est_d   = est_q;
    cnt_d   = cnt_q;
    model_d = model_q;
    first_d = first_q;
    pass_d  = pass_q;
    j_d     = 1'b0;
    k_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          pat_d   = bus.pattern;
          cnt_d   = '0;
          est_d   = '0;
          first_d = 1'b0;
          pass_d  = 1'b0;
          idx_d   = '0;
          k_d     = 1'b1;
          state_d = INIT_APPLY;
        end
      end
      INIT_APPLY: begin
        model_d = 1'b0;
        state_d = INIT_CHECK;
      end
      INIT_CHECK: begin
        if (n_mis != 2'd0) begin
          cnt_d = cnt_sat;
          if (!first_q) begin
            first_d = 1'b1;
            est_d   = LAST;
          end
        end
        {j_d, k_d} = step_cur;
        state_d    = APPLY;
      end
      APPLY: begin
        unique case ({j_q, k_q})
          2'b01:   model_d = 1'b0;
          2'b10:   model_d = 1'b1;
          2'b11:   model_d = ~model_q;
          default: model_d = model_q;
        endcase
        state_d = CHECK;
      end
      CHECK: begin
        if (n_mis != 2'd0) begin
          cnt_d = cnt_sat;
          if (!first_q) begin
            first_d = 1'b1;
            est_d   = idx_q;
          end
        end
        if (idx_q == LAST) begin
          pass_d  = (cnt_d == '0);
          state_d = DONE;
        end else begin
          idx_d      = idx_inc;
          {j_d, k_d} = step_nxt;
          state_d    = APPLY;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pat_q   <= '0;
      idx_q   <= '0;
      est_q   <= '0;
      cnt_q   <= '0;
      model_q <= 1'b0;
      first_q <= 1'b0;
      pass_q  <= 1'b0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      est_q   <= est_d;
      cnt_q   <= cnt_d;
      model_q <= model_d;
      first_q <= first_d;
      pass_q  <= pass_d;
      j_q     <= j_d;
      k_q     <= k_d;
    end
  end

  assign bus.j        = j_q;
  assign bus.k        = k_q;
  assign bus.busy     = (state_q != IDLE)
                     && (state_q != DONE);
  assign bus.done     = (state_q == DONE);
  assign bus.pass     = pass_q;
  assign bus.err_cnt  = cnt_q;
  assign bus.err_step = est_q;

endmodule

// File: tb/tb_jk_ff_exerciser.sv
// Scoreboard bench for jk_ff_exerciser against a behavioural JK cell.
// Fault modes: stuck-at-0/1 q and q_bar tied to q.
module tb_jk_ff_exerciser;
  localparam int STEPS = 8;
  localparam int IDX_W = 4;
  localparam int CNT_W = 3;
  localparam int LAT   = 2 + 2*STEPS;
`ifdef JK_CHK_QBAR_EN
  localparam bit QB = 1'b1;
`else
  localparam bit QB = 1'b0;
`endif

  typedef struct {
    int pass;
    int cnt;
    int step;
    int lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ff_q = 1'b0;
  logic [1:0] mode = 2'd0;
  logic qb_tie = 1'b0;
  logic jk_prev = 1'b0;
  int jk_bad = 0;
  int busy_cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  exp_t sb[$];

  jk_ff_exerciser_if #(
    .STEPS(STEPS), .IDX_W(IDX_W), .CNT_W(CNT_W)
  ) bus ();

  jk_ff_exerciser #(
    .STEPS(STEPS), .IDX_W(IDX_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    case ({bus.j, bus.k})
      2'b01:   ff_q <= 1'b0;
      2'b10:   ff_q <= 1'b1;
      2'b11:   ff_q <= ~ff_q;
      default: ff_q <= ff_q;
    endcase
  end

  assign bus.q_in = (mode == 2'd1) ? 1'b0
                  : (mode == 2'd2) ? 1'b1 : ff_q;
  assign bus.q_bar_in = qb_tie ? bus.q_in : ~bus.q_in;

  task automatic chk(input string nm,
                     input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cyc = 0;
      jk_prev  = 1'b0;
    end else begin
      if (bus.busy) busy_cyc++;
      if ((bus.j | bus.k) && jk_prev) jk_bad++;
      jk_prev = bus.j | bus.k;
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("pass", int'(bus.pass), e.pass);
          chk("err_cnt", int'(bus.err_cnt), e.cnt);
          chk("err_step", int'(bus.err_step), e.step);
          chk("latency", busy_cyc, e.lat);
        end
        busy_cyc = 0;
      end
    end
  end

  task automatic run(input logic [15:0] pat,
                     input logic [1:0] m,
                     input logic tie,
                     input exp_t e,
                     input bit poke);
    int t;
    mode   = m;
    qb_tie = tie;
    sb.push_back(e);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.pattern = pat;
    @(negedge clk);
    bus.start = 1'b0;
    if (poke) begin
      repeat (3) @(negedge clk);
      bus.start   = 1'b1;
      bus.pattern = 16'h5555;
      repeat (2) @(negedge clk);
      bus.start = 1'b0;
    end
    t = 0;
    while (!bus.done && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      chk("done_timeout", t, 0);
      sb.delete();
    end
    @(negedge clk);
    chk("pass_hold", int'(bus.pass), e.pass);
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.pattern = '0;
    repeat (2) @(negedge clk);
    chk("rst_j", int'(bus.j), 0);
    chk("rst_k", int'(bus.k), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_pass", int'(bus.pass), 0);
    chk("rst_cnt", int'(bus.err_cnt), 0);
    chk("rst_step", int'(bus.err_step), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // hold/reset/set/hold/toggle/toggle/reset/set
    run(16'h9F24, 2'd0, 1'b0, '{1, 0, 0, LAT}, 1'b0);
    // all toggle
    run(16'hFFFF, 2'd0, 1'b0, '{1, 0, 0, LAT}, 1'b0);
    // stuck-at-0: set at step 2 then hold misses twice
    run(16'h5524, 2'd1, 1'b0, '{0, 2, 2, LAT}, 1'b0);
    // stuck-at-1 holding 0: every check fails, counter saturates
    run(16'h0000, 2'd2, 1'b0, '{0, 7, 7, LAT}, 1'b1);

    // abort during APPLY of step 1
    mode = 2'd0;
    qb_tie = 1'b0;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.pattern = 16'h9F24;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("apply1_j", int'(bus.j), 0);
    chk("apply1_k", int'(bus.k), 1);
    chk("apply1_busy", int'(bus.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_j", int'(bus.j), 0);
    chk("abort_k", int'(bus.k), 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(16'h9F24, 2'd0, 1'b0, '{1, 0, 0, LAT}, 1'b0);

    // q_bar tied to q on a good cell
    if (QB) run(16'h9F24, 2'd0, 1'b1, '{0, 7, 7, LAT}, 1'b0);
    else    run(16'h9F24, 2'd0, 1'b1, '{1, 0, 0, LAT}, 1'b0);

    repeat (3) @(negedge clk);
    chk("jk_back_to_back", jk_bad, 0);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
